// File: rtl/elevator_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elevator_motion_ctrl
// Brief    : Floor-by-floor car motion controller stepped by the divider's slow
//            level, with latched requests, timed door and divider enable.
//            Optional emergency stop: define MOTION_ESTOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_motion_ctrl #(
  parameter int N_FLOORS   = 8,
  parameter int FLOOR_W    = 3,
  parameter int DOOR_TICKS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slow_lvl,
  input  logic [N_FLOORS-1:0] req,
`ifdef MOTION_ESTOP_EN
  input  logic                estop,
  output logic                halted,
`endif
  output logic                div_en,
  output logic [FLOOR_W-1:0]  floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

  localparam int                 CNT_W     = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [CNT_W-1:0]   DOOR_LOAD = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  logic estop_w;
`ifdef MOTION_ESTOP_EN
  assign estop_w = estop;
`else
  assign estop_w = 1'b0;
`endif

  logic [1:0]          state, state_n;
  logic [FLOOR_W-1:0]  floor_n;
  logic                dir_n;
  logic [CNT_W-1:0]    door_cnt, cnt_n;
  logic [N_FLOORS-1:0] clr;
  logic                moving_q;

  // armed blocks a step on a level that was already high when reset released
  logic slow_q, armed, step;
  assign step = slow_lvl & ~slow_q & armed & ~estop_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      slow_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      slow_q <= slow_lvl;
      armed  <= armed | ~slow_lvl;
    end
  end

  logic [N_FLOORS-1:0] here_oh, up_oh, dn_oh;
  logic                above, below, above_up, below_dn;

  always_comb begin
    here_oh  = '0;
    up_oh    = '0;
    dn_oh    = '0;
    above    = 1'b0;
    below    = 1'b0;
    above_up = 1'b0;
    below_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      here_oh[i] = (i == int'(floor));
      up_oh[i]   = (i == int'(floor) + 1);
      dn_oh[i]   = (i == int'(floor) - 1);
      if (i > int'(floor))     above    = above    | pending[i];
      if (i < int'(floor))     below    = below    | pending[i];
      if (i > int'(floor) + 1) above_up = above_up | pending[i];
      if (i < int'(floor) - 1) below_dn = below_dn | pending[i];
    end
  end

  logic hit_here, hit_up, hit_dn, req_here;
  assign hit_here = |(pending & here_oh);
  assign hit_up   = |(pending & up_oh);
  assign hit_dn   = |(pending & dn_oh);
  assign req_here = |(req & here_oh);

  always_comb begin
    state_n = state;
    floor_n = floor;
    dir_n   = dir_up;
    cnt_n   = door_cnt;
    clr     = '0;
    case (state)
      S_IDLE: begin
        if (step) begin
          if (hit_here) begin
            state_n = S_DOOR;
            clr     = here_oh;
            cnt_n   = DOOR_LOAD;
          end else if (above & (dir_up | ~below)) begin
            state_n = S_UP;
            dir_n   = 1'b1;
          end else if (below) begin
            state_n = S_DOWN;
            dir_n   = 1'b0;
          end
        end
      end
      S_UP: begin
        if (step) begin
          if (floor == TOP_FLOOR) begin
            state_n = S_IDLE;
          end else begin
            floor_n = floor + 1'b1;
            if (hit_up) begin
              state_n = S_DOOR;
              clr     = up_oh;
              cnt_n   = DOOR_LOAD;
            end else if (!above_up) begin
              state_n = S_IDLE;
            end
          end
        end
      end
      S_DOWN: begin
        if (step) begin
          if (floor == '0) begin
            state_n = S_IDLE;
          end else begin
            floor_n = floor - 1'b1;
            if (hit_dn) begin
              state_n = S_DOOR;
              clr     = dn_oh;
              cnt_n   = DOOR_LOAD;
            end else if (!below_dn) begin
              state_n = S_IDLE;
            end
          end
        end
      end
      default: begin
        clr = here_oh;
        // a call at the open floor keeps the door open instead of latching
        if (req_here & ~estop_w) begin
          cnt_n = DOOR_LOAD;
        end else if (step) begin
          if (door_cnt == '0) state_n = S_IDLE;
          else                cnt_n   = door_cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      floor     <= '0;
      dir_up    <= 1'b1;
      door_cnt  <= '0;
      pending   <= '0;
      moving_q  <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_n;
      floor     <= floor_n;
      dir_up    <= dir_n;
      door_cnt  <= cnt_n;
      pending   <= (pending | req) & ~clr;
      moving_q  <= (state_n == S_UP) | (state_n == S_DOWN);
      door_open <= (state_n == S_DOOR);
    end
  end

  assign moving = moving_q & ~estop_w;
  assign div_en = (state != S_IDLE) | (|pending) | (|req);

`ifdef MOTION_ESTOP_EN
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= estop;
  end
`endif

endmodule
`default_nettype wire
